// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the chunk-serial adder:
//     - state_t     : control FSM states (IDLE / RUN / DONE)
//     - idx_width() : width of the chunk index counter, never below 1 bit
//     - params_ok() : legality of a WIDTH / CHUNK pairing, used for an
//                     elaboration-time check in the top level
//   No ports (package).
// ---------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A counter over a single chunk still needs one bit to exist.
    function automatic int idx_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

    function automatic bit params_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
//   Purely combinational CHUNK-bit ripple-carry adder built from explicit
//   full-adder equations, so each bit stays a separate candidate for
//   approximation partitioning.
//   Ports:
//     x, y  [CHUNK] in   addends
//     ci          in   carry into bit 0
//     s     [CHUNK] out  sum bits
//     co          out  carry out of bit CHUNK-1
//     c_msb       out  carry into bit CHUNK-1 (for signed-overflow detection)
// ---------------------------------------------------------------------------
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    // c[i] is the carry into bit i; c[CHUNK] is the carry out.
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic p;
        assign p      = x[i] ^ y[i];
        assign s[i]   = p ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & p);
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder
//   Chunk-serial WIDTH-bit add/subtract unit. One shared chunk_adder processes
//   CHUNK bits per clock, with the carry held in a register between chunks.
//   An operation takes NCHUNK = WIDTH/CHUNK RUN cycles, followed by a DONE
//   state that holds the result until the consumer takes it.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_valid / in_ready   operand handshake (a, b, cin, sub)
//     a, b        [WIDTH]   operands
//     cin                   carry-in (add) / borrow-in (sub)
//     sub                   0: a+b+cin   1: a-b-cin
//     out_valid / out_ready result handshake (sum, cout, ovf)
//     sum         [WIDTH]   result, modulo 2^WIDTH
//     cout                  carry out of the MSB (for sub: 1 = no borrow)
//     ovf                   two's-complement overflow
// ---------------------------------------------------------------------------
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] ch_x, ch_y, ch_s;
    logic             ch_co, ch_cmsb;

    assign ch_x = a_q[idx_q*CHUNK +: CHUNK];
    assign ch_y = b_q[idx_q*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .x     (ch_x),
        .y     (ch_y),
        .ci    (carry_q),
        .s     (ch_s),
        .co    (ch_co),
        .c_msb (ch_cmsb)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract as a + ~b + ~cin: invert B once at load time
                    // and fold sub into the initial carry.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = ch_s;
                carry_d = ch_co;
                if (idx_q == LAST_IDX) begin
                    // The last chunk holds bit WIDTH-1, so its top-bit carries
                    // are the full-width MSB carries.
                    cout_d  = ch_co;
                    ovf_d   = ch_cmsb ^ ch_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: the operand registers carry no reset; they are always loaded on
    // acceptance before being read, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    // Outputs are forced low while rst is high, including the cycle in which
    // reset is first asserted over a DONE or RUN state.
    assign in_ready  = !rst && (state_q == IDLE);
    assign out_valid = !rst && (state_q == DONE);
    assign sum       = rst ? '0 : sum_q;
    assign cout      = !rst && cout_q;
    assign ovf       = !rst && ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_chunk_adder
//   Three WIDTH=8 instances: CHUNK=4 (directed cases), CHUNK=8 and CHUNK=1
//   (random sweeps against an arithmetic reference). Expected results are
//   pushed into per-instance queues at acceptance; a negedge monitor pops and
//   compares whenever a result is handed over.
// ---------------------------------------------------------------------------
module tb_seq_chunk_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       cin, sub;
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [7:0] sum_o     [3];
    logic       cout_o    [3];
    logic       ovf_o     [3];

    exp_t q0[$], q1[$], q2[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0])
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_c8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1])
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Independent arithmetic reference: widen and add, carry into the MSB
    // taken from a 7-bit add of the lower bits.
    function automatic exp_t ref_model(input logic [7:0] x, input logic [7:0] y,
                                       input logic ci, input logic s);
        exp_t       r;
        logic [7:0] yy;
        logic [8:0] full;
        logic [7:0] low;
        yy     = s ? ~y : y;
        full   = {1'b0, x} + {1'b0, yy} + {8'd0, ci ^ s};
        low    = {1'b0, x[6:0]} + {1'b0, yy[6:0]} + {7'd0, ci ^ s};
        r.sum  = full[7:0];
        r.cout = full[8];
        r.ovf  = low[7] ^ full[8];
        return r;
    endfunction

    function automatic exp_t mk(input logic [7:0] s, input logic c, input logic o);
        exp_t r;
        r.sum  = s;
        r.cout = c;
        r.ovf  = o;
        return r;
    endfunction

    task automatic push_exp(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic consume(input int i);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (i)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        check($sformatf("expected_result_pending[%0d]", i), 32'(have), 32'd1);
        if (have) begin
            check($sformatf("sum[%0d]", i),  32'(sum_o[i]),  32'(e.sum));
            check($sformatf("cout[%0d]", i), 32'(cout_o[i]), 32'(e.cout));
            check($sformatf("ovf[%0d]", i),  32'(ovf_o[i]),  32'(e.ovf));
        end
    endtask

    // Monitor: a result is handed over on the edge following a negedge that
    // sees out_valid && out_ready.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (out_valid[i] && out_ready[i]) consume(i);
        end
    end

    // Drives one operation at posedge+1, checks acceptance, latency and
    // in_ready during the operation. Returns 1 time unit after the edge that
    // raised out_valid, or after the return to IDLE when out_ready is high.
    task automatic run_op(input int i, input logic [7:0] va, input logic [7:0] vb,
                          input logic vcin, input logic vsub, input exp_t e,
                          input int lat_exp);
        int n;
        a           = va;
        b           = vb;
        cin         = vcin;
        sub         = vsub;
        in_valid[i] = 1'b1;
        n = 0;
        while (!in_ready[i] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("accept_within_bound[%0d]", i), 32'(n < 50), 32'd1);
        push_exp(i, e);
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        a = 8'hxx;
        b = 8'hxx;
        n = 0;
        while (!out_valid[i] && n < 50) begin
            check($sformatf("in_ready_busy[%0d]", i), 32'(in_ready[i]), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("latency[%0d]", i), n, lat_exp);
        check($sformatf("in_ready_done[%0d]", i), 32'(in_ready[i]), 32'd0);
        if (out_ready[i]) begin
            @(posedge clk); #1;
            check($sformatf("idle_after_handover[%0d]", i), 32'(out_valid[i]), 32'd0);
        end
    endtask

    initial begin
        exp_t e;
        logic [7:0] ra, rb;
        logic       rc, rs;

        rst = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready[0]),  32'd0);
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_sum",       32'(sum_o[0]),     32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready[0]), 32'd1);

        // Directed cases on CHUNK=4 (latency 2).
        run_op(0, 8'h0F, 8'h01, 1'b0, 1'b0, mk(8'h10, 1'b0, 1'b0), 2); // carry across chunks
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1), 2); // signed overflow
        run_op(0, 8'hFF, 8'h00, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b0), 2); // wrap via cin
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, mk(8'hFE, 1'b0, 1'b0), 2); // borrow
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, mk(8'h7F, 1'b1, 1'b1), 2); // sub overflow
        run_op(0, 8'h10, 8'h03, 1'b1, 1'b1, mk(8'h0C, 1'b1, 1'b0), 2); // sub with borrow-in

        // Backpressure: hold out_ready low for 5 cycles in DONE.
        out_ready[0] = 1'b0;
        run_op(0, 8'h3C, 8'h44, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1), 2);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 32'(out_valid[0]), 32'd1);
            check("bp_sum",       32'(sum_o[0]),     32'h80);
            check("bp_cout",      32'(cout_o[0]),    32'd0);
            check("bp_ovf",       32'(ovf_o[0]),     32'd1);
            check("bp_in_ready",  32'(in_ready[0]),  32'd0);
            @(posedge clk); #1;
        end
        // Release together with a queued request; the request must wait.
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        a = 8'hA5; b = 8'h5A; cin = 1'b1; sub = 1'b0;
        check("bp_queued_not_taken", 32'(in_ready[0]), 32'd0);
        @(posedge clk); #1;
        check("bp_release_idle_valid", 32'(out_valid[0]), 32'd0);
        check("bp_release_idle_ready", 32'(in_ready[0]),  32'd1);
        run_op(0, 8'hA5, 8'h5A, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b0), 2);

        // Reset during the first RUN cycle discards the operation.
        a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        rst = 1'b1;
        check("midrst_in_ready_now", 32'(in_ready[0]), 32'd0);
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        check("midrst_sum",       32'(sum_o[0]),     32'd0);
        check("midrst_cout",      32'(cout_o[0]),    32'd0);
        check("midrst_ovf",       32'(ovf_o[0]),     32'd0);
        rst = 1'b0;
        #1;
        check("midrst_back_idle", 32'(in_ready[0]), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("midrst_no_result", 32'(out_valid[0]), 32'd0);
        end
        run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, mk(8'h46, 1'b0, 1'b0), 2);

        // Random sweeps against the reference: CHUNK=8 (latency 1), CHUNK=1 (latency 8).
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            rc = 1'($urandom_range(1));
            rs = 1'($urandom_range(1));
            e  = ref_model(ra, rb, rc, rs);
            run_op(1, ra, rb, rc, rs, e, 1);
        end
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            rc = 1'($urandom_range(1));
            rs = 1'($urandom_range(1));
            e  = ref_model(ra, rb, rc, rs);
            run_op(2, ra, rb, rc, rs, e, 8);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised, chunk-serial successor to the team's fixed 4-bit ripple-carry adder partition.
- Adds two WIDTH-bit operands, CHUNK bits per clock, through one shared chunk adder and a registered carry.
- Supports add and subtract, carry/borrow-in, and a signed-overflow flag.
- Operands arrive on a valid/ready input handshake; results leave on a valid/ready output handshake. Used where a full-width combinational adder is too large for approximation partitioning.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, cycles per operation.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out (for sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow.

Behaviour:
- Reset and outputs:
  - While rst is high: state IDLE; sum, cout, ovf, out_valid = 0; in_ready = 0.
  - in_ready = 1 only in IDLE with rst low.
  - rst has priority over every other event. Asserting it mid-RUN or in DONE discards the operation and its result, and no out_valid is ever produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - Acceptance happens when in_valid && in_ready.
  - On acceptance, latch a into a_r and b^{WIDTH{sub}} into b_r.
  - Load carry_r = cin^sub, clear idx, clear the sum register, go to RUN.
  - Operand inputs are ignored when not accepted.
- RUN, one chunk per cycle:
  - Chunk k = idx, covering bits [k*CHUNK +: CHUNK].
  - sum[k] <= a_r[k] + b_r[k] + carry_r; carry_r <= chunk carry-out; idx <= idx+1.
  - When idx == NCHUNK-1: load cout <= chunk carry-out and ovf <= (carry into MSB) ^ (chunk carry-out), then go to DONE.
- DONE:
  - out_valid = 1; sum, cout and ovf stay stable.
  - On out_ready, go to IDLE with out_valid = 0 on the next cycle.
  - in_ready = 0 throughout DONE, so there is no overlap of result and new acceptance.
- Latency and throughput:
  - If the acceptance edge is cycle 0, out_valid is first high after edge NCHUNK.
  - Minimum spacing between acceptances is NCHUNK+2 cycles (accept, NCHUNK RUN edges, DONE handshake edge).
- Arithmetic:
  - Modulo 2^WIDTH.
  - Subtract uses one's complement of B with effective carry-in = ~cin, so sub=1, cin=0 computes A-B.
  - cout is the raw carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; valid for both add and sub.
- Boundary cases:
  - NCHUNK = 1: exactly one RUN cycle.
  - idx width = max(1, clog2(NCHUNK)); idx never exceeds NCHUNK-1, and wrap-around is impossible.
  - out_ready held low keeps DONE indefinitely.
  - out_ready high outside DONE has no effect.
  - in_valid high outside IDLE is not consumed; the producer must hold it.
- sum updates chunk-wise during RUN, but is only meaningful while out_valid = 1.

Decomposition:
- Shared package adder_pkg:
  - state enum (IDLE/RUN/DONE).
  - function for idx width.
  - elaboration checks WIDTH % CHUNK == 0 and CHUNK >= 1.
- Sub-module chunk_adder #(CHUNK), purely combinational:
  - inputs x[CHUNK], y[CHUNK], ci.
  - outputs s[CHUNK], co, c_msb (carry into top bit).
  - Gate-level ripple so it stays a target for approximation partitioning.
- seq_chunk_adder holds the FSM, operand/sum registers, carry_r and idx.

Test Plan (WIDTH=8, CHUNK=4 unless noted):
- Carry across chunks: a=0x0F, b=0x01, cin=0, sub=0 → sum=0x10, cout=0, ovf=0. out_valid first high 2 cycles after the accept edge. in_ready=0 from accept until the return to IDLE.
- Overflow and wrap: a=0x7F, b=0x01 → sum=0x80, ovf=1, cout=0. a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1, ovf=0.
- Subtract: a=0x05, b=0x07, sub=1, cin=0 → sum=0xFE, cout=0 (borrow), ovf=0. a=0x80, b=0x01, sub=1 → sum=0x7F, ovf=1, cout=1.
- Backpressure: result ready with out_ready low for 5 cycles → out_valid, sum, cout, ovf stable and in_ready=0. Raising out_ready → IDLE next cycle; a queued in_valid is then accepted.
- Reset mid-operation: rst high on the first RUN cycle → next cycle all outputs 0, state IDLE, no out_valid for the dropped operation. A new operation afterwards completes correctly.
- Single-chunk configuration (WIDTH=CHUNK=8) and CHUNK=1 with WIDTH=8: random 1000-vector comparison against a reference model for sum, cout and ovf. Latency is 1 and 8 cycles respectively.
